// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_tx_fifo_pkg;

  // Transmitter FSM states; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Line level of the parity bit for a (zero-extended) data word.
  function automatic logic parity_bit(input int mode, input logic [7:0] data);
    if (mode == PAR_ODD)  return ~^data;
    if (mode == PAR_EVEN) return ^data;
    return 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes on full and pops on empty are ignored.
module uart_sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next occupancy: a push and a pop in the same cycle cancel out.
  always_comb begin
    // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and count registers; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, fractional baud generator and framing FSM.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rstn_i,
  input  logic                 uart_wr_i,
  input  logic [DATA_BITS-1:0] uart_dat_i,
  input  logic                 uart_ovf_clr_i,
  output logic                 uart_tx,
  output logic                 uart_full_o,
  output logic                 uart_empty_o,
  output logic                 uart_busy_o,
  output logic                 uart_ovf_o
);

  localparam int ACC_W = clog2(CLK_HZ) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam int IDX_W = clog2(DATA_BITS);
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  localparam logic [SUM_W-1:0] BAUD_INC   = SUM_W'(BAUD);
  localparam logic [SUM_W-1:0] CLK_WRAP   = SUM_W'(CLK_HZ);
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST  = (STOP_BITS == 2);
  localparam bit               HAS_PARITY = (PARITY != PAR_NONE);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_cnt_q;
  logic                 tx_q;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [SUM_W-1:0]     acc_sum;
  logic                 baud_tick;

  logic                 ovf_q, ovf_d;

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  logic                 frame_from_idle, stop_done;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rstn_i),
    .push_i  (uart_wr_i),
    .pop_i   (fifo_pop),
    .din_i   (uart_dat_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Pop the head when idle, or at the final stop tick to chain frames without a gap.
  always_comb begin
    stop_done       = (state_q == ST_STOP) && baud_tick && (stop_cnt_q == STOP_LAST);
    frame_from_idle = (state_q == ST_IDLE) && !fifo_empty;
    fifo_pop        = !fifo_empty && ((state_q == ST_IDLE) || stop_done);
  end

  // Phase accumulator: tick when the accumulated phase crosses CLK_HZ, keeping the remainder.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + BAUD_INC;
    baud_tick = (acc_sum >= CLK_WRAP);
    acc_d     = baud_tick ? ACC_W'(acc_sum - CLK_WRAP) : acc_sum[ACC_W-1:0];
    if (frame_from_idle) acc_d = '0;
  end

  // Baud accumulator register.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) acc_q <= '0;
    else             acc_q <= acc_d;
  end

  // Sticky overflow: a write against a full FIFO sets it, and set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (uart_ovf_clr_i)          ovf_d = 1'b0;
    if (uart_wr_i && fifo_full)  ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) ovf_q <= 1'b0;
    else             ovf_q <= ovf_d;
  end

  // Framing FSM with a registered line output; bits advance only on baud ticks.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            shift_q <= fifo_dout;
            par_q   <= parity_bit(PARITY, 8'(fifo_dout));
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == DATA_LAST) begin
              if (HAS_PARITY) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q    <= ST_STOP;
                stop_cnt_q <= 1'b0;
                tx_q       <= 1'b1;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            state_q    <= ST_STOP;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == STOP_LAST) begin
              if (fifo_pop) begin
                shift_q <= fifo_dout;
                par_q   <= parity_bit(PARITY, 8'(fifo_dout));
                state_q <= ST_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx      = tx_q;
  assign uart_full_o  = fifo_full;
  assign uart_empty_o = fifo_empty;
  assign uart_busy_o  = (state_q != ST_IDLE) || (fifo_count != '0);
  assign uart_ovf_o   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations share clock and reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] wr_v;
  logic [7:0] dat;
  logic       clr;
  logic [3:0] tx_v, full_v, empty_v, busy_v, ovf_v;
  logic [1:0] sel;
  logic       tx_m, full_m, empty_m, busy_m, ovf_m;
  int         passes = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Observe the instance selected by the current test step.
  always_comb begin
    tx_m    = tx_v[sel];
    full_m  = full_v[sel];
    empty_m = empty_v[sel];
    busy_m  = busy_v[sel];
    ovf_m   = ovf_v[sel];
  end

  // 0: 16/1 8N1, 1: 8E2, 2: 8O2, 3: 100 MHz / 115200 8N1
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr_v[0]), .uart_dat_i(dat), .uart_ovf_clr_i(clr),
    .uart_tx(tx_v[0]), .uart_full_o(full_v[0]), .uart_empty_o(empty_v[0]), .uart_busy_o(busy_v[0]),
    .uart_ovf_o(ovf_v[0]));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr_v[1]), .uart_dat_i(dat), .uart_ovf_clr_i(clr),
    .uart_tx(tx_v[1]), .uart_full_o(full_v[1]), .uart_empty_o(empty_v[1]), .uart_busy_o(busy_v[1]),
    .uart_ovf_o(ovf_v[1]));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr_v[2]), .uart_dat_i(dat), .uart_ovf_clr_i(clr),
    .uart_tx(tx_v[2]), .uart_full_o(full_v[2]), .uart_empty_o(empty_v[2]), .uart_busy_o(busy_v[2]),
    .uart_ovf_o(ovf_v[2]));
  uart_tx_fifo #(.CLK_HZ(100000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4)) u_d (
    .sys_clk_i(clk), .sys_rstn_i(rst_n), .uart_wr_i(wr_v[3]), .uart_dat_i(dat), .uart_ovf_clr_i(clr),
    .uart_tx(tx_v[3]), .uart_full_o(full_v[3]), .uart_empty_o(empty_v[3]), .uart_busy_o(busy_v[3]),
    .uart_ovf_o(ovf_v[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line level of an 8N1 frame of byte b during bit period p.
  function automatic logic frame_level(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  // Write one byte while idle, then compare the line against a hand-built bit pattern.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [15:0] pat, input int nper);
    dat  = d;
    wr_v = 4'b0001 << sel;
    step();
    wr_v = '0;
    check({tag, " pre-pop tx"}, tx_m, 1'b1);
    check({tag, " pre-pop empty"}, empty_m, 1'b0);
    check({tag, " pre-pop busy"}, busy_m, 1'b1);
    step();
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < 16; c++) begin
        check($sformatf("%s bit%0d cyc%0d", tag, p, c), tx_m, pat[p]);
        if (c == 8) check($sformatf("%s busy bit%0d", tag, p), busy_m, 1'b1);
        step();
      end
    end
    check({tag, " end busy"}, busy_m, 1'b0);
    check({tag, " end tx"}, tx_m, 1'b1);
  endtask

  // Back-to-back writes of base, base+1, ... into instance 0; expects five frames, no gaps.
  task automatic burst(input string tag, input logic [7:0] base, input int nwr, input bit clash);
    logic exp_l;
    int   f;
    dat  = base;
    wr_v = 4'b0001 << sel;
    step();
    dat = 8'(base + 1);
    step();
    for (int k = 0; k < 5 * 160 + 16; k++) begin
      f     = k / 160;
      exp_l = (f < 5) ? frame_level(8'(base + f), (k % 160) / 16) : 1'b1;
      check($sformatf("%s tx k%0d", tag, k), tx_m, exp_l);
      if (k == 3)  check({tag, " full"}, full_m, 1'b1);
      if (k == 4)  check({tag, " ovf"}, ovf_m, (nwr > 5));
      if (clash && k == 12) check({tag, " ovf set beats clr"}, ovf_m, 1'b1);
      if (k == 400) check({tag, " ovf later"}, ovf_m, (nwr > 5));
      clr = 1'b0;
      if (k + 2 < nwr) begin
        dat  = 8'(base + k + 2);
        wr_v = 4'b0001 << sel;
      end else if (clash && k == 10) begin
        dat  = 8'hEE;
        wr_v = 4'b0001 << sel;
        clr  = 1'b1;
      end else begin
        wr_v = '0;
      end
      step();
    end
    check({tag, " end busy"}, busy_m, 1'b0);
    check({tag, " end tx"}, tx_m, 1'b1);
  endtask

  int   t_edge [64];
  int   n_edge, cyc, t_end, per;
  logic prev;
  bit   bad;

  initial begin
    rst_n = 1'b0;
    wr_v  = '0;
    dat   = '0;
    clr   = 1'b0;
    sel   = 2'd0;
    step();
    step();
    check("rst tx", tx_m, 1'b1);
    check("rst full", full_m, 1'b0);
    check("rst empty", empty_m, 1'b1);
    check("rst busy", busy_m, 1'b0);
    check("rst ovf", ovf_m, 1'b0);
    rst_n = 1'b1;
    step();
    step();

    // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
    sel = 2'd0;
    send_one("t1 A5", 8'hA5, 16'h034A, 10);

    // 8E2 and 8O2, 0x07: 0,1,1,1,0,0,0,0,0,P,1,1
    sel = 2'd1;
    send_one("t2 even", 8'h07, 16'h0E0E, 12);
    sel = 2'd2;
    send_one("t2 odd", 8'h07, 16'h0C0E, 12);

    // Five writes fill the FIFO exactly; frames chain with no idle gap.
    sel = 2'd0;
    burst("t3", 8'h01, 5, 1'b0);
    check("t3 ovf final", ovf_m, 1'b0);

    // Six writes: the sixth is dropped; a second full-write coincides with clear.
    burst("t4", 8'h30, 6, 1'b1);
    check("t4 ovf held", ovf_m, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4 ovf cleared", ovf_m, 1'b0);

    // Fractional baud: four 0x55 frames toggle the line every bit period.
    sel    = 2'd3;
    n_edge = 0;
    cyc    = 0;
    t_end  = -1;
    prev   = 1'b1;
    dat    = 8'h55;
    wr_v   = 4'b0001 << sel;
    while (t_end < 0 && cyc < 40000) begin
      if (cyc == 4) wr_v = '0;
      step();
      cyc++;
      if (tx_m !== prev) begin
        if (n_edge < 64) t_edge[n_edge] = cyc;
        n_edge++;
        prev = tx_m;
      end
      if (cyc > 4 && busy_m === 1'b0) t_end = cyc;
    end
    wr_v = '0;
    check("t5 finished", (t_end > 0), 1'b1);
    check("t5 transitions", n_edge, 40);
    for (int i = 0; i < 40; i++) begin
      per = (i < 39) ? t_edge[i+1] - t_edge[i] : t_end - t_edge[39];
      check($sformatf("t5 period%0d=%0d", i, per), (per >= 868 && per <= 869), 1'b1);
    end
    per = t_edge[30] - t_edge[0];
    check($sformatf("t5 3-frame span=%0d", per), (per >= 26041 && per <= 26042), 1'b1);
    per = t_end - t_edge[0];
    check($sformatf("t5 4-frame span=%0d", per), (per >= 34722 && per <= 34723), 1'b1);

    // Reset in the middle of a data bit with three bytes queued.
    sel  = 2'd0;
    dat  = 8'h00;
    wr_v = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    wr_v = '0;
    for (int i = 0; i < 40; i++) step();
    check("t6 mid-data tx", tx_m, 1'b0);
    check("t6 queued", empty_m, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async tx", tx_m, 1'b1);
    check("t6 async full", full_m, 1'b0);
    check("t6 async empty", empty_m, 1'b1);
    check("t6 async busy", busy_m, 1'b0);
    check("t6 async ovf", ovf_m, 1'b0);
    step();
    step();
    #2;
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx_m !== 1'b1 || busy_m !== 1'b0) bad = 1'b1;
    end
    check("t6 idle after release", bad, 1'b0);
    // 0x5A: 0,0,1,0,1,1,0,1,0,1
    send_one("t6 5A", 8'h5A, 16'h02B4, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
